// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the RV32 main control: opcodes, ALU operation codes
// and the control bundles carried through the ID/EX, EX/MEM and MEM/WB registers.
package ctrl_pipe_pkg;

   localparam logic [6:0] OP_NOP = 7'b0000000;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_RTYPE = 2'b10,
      ALU_ITYPE = 2'b11
   } alu_op_e;

   typedef struct packed {
      alu_op_e alu_op;
      logic    alu_src;
      logic    branch;
      logic    jump;
      logic    mem_read;
      logic    mem_write;
      logic    reg_write;
      logic    mem_to_reg;
   } ex_ctrl_t;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic reg_write;
      logic mem_to_reg;
   } mem_ctrl_t;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } wb_ctrl_t;

   // Later stages keep only the fields they or their successors still consume.
   function automatic mem_ctrl_t to_mem(input ex_ctrl_t b);
      return '{mem_read: b.mem_read, mem_write: b.mem_write,
               reg_write: b.reg_write, mem_to_reg: b.mem_to_reg};
   endfunction

   function automatic wb_ctrl_t to_wb(input mem_ctrl_t b);
      return '{reg_write: b.reg_write, mem_to_reg: b.mem_to_reg};
   endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Control-path signal bundle between the hazard/ID logic (master) and ctrl_pipe (slave).
interface ctrl_pipe_if #(
   parameter int ALUOP_W = 2,
   parameter int CNT_W   = 8
);
   logic [6:0]         op_i;
   logic               noop_i;
   logic               flush_i;
   logic               stall_i;
   logic               cnt_clr_i;
   logic               illegal_o;
   logic [ALUOP_W-1:0] ex_alu_op_o;
   logic               ex_alu_src_o;
   logic               ex_branch_o;
   logic               ex_jump_o;
   logic               ex_mem_read_o;
   logic               ex_reg_write_o;
   logic               mem_mem_read_o;
   logic               mem_mem_write_o;
   logic               mem_reg_write_o;
   logic               wb_reg_write_o;
   logic               wb_mem_to_reg_o;
   logic [CNT_W-1:0]   illegal_cnt_o;

   modport master (
      output op_i, noop_i, flush_i, stall_i, cnt_clr_i,
      input  illegal_o, ex_alu_op_o, ex_alu_src_o, ex_branch_o, ex_jump_o,
             ex_mem_read_o, ex_reg_write_o, mem_mem_read_o, mem_mem_write_o,
             mem_reg_write_o, wb_reg_write_o, wb_mem_to_reg_o, illegal_cnt_o
   );

   modport slave (
      input  op_i, noop_i, flush_i, stall_i, cnt_clr_i,
      output illegal_o, ex_alu_op_o, ex_alu_src_o, ex_branch_o, ex_jump_o,
             ex_mem_read_o, ex_reg_write_o, mem_mem_read_o, mem_mem_write_o,
             mem_reg_write_o, wb_reg_write_o, wb_mem_to_reg_o, illegal_cnt_o
   );
endinterface

// File: rtl/ctrl_pipe_decode.sv
// Combinational opcode decoder: ID-stage opcode to full control bundle plus illegal flag.
module ctrl_pipe_decode
   import ctrl_pipe_pkg::*;
#(
   parameter bit SUPPORT_JAL = 1'b1
) (
   input  logic [6:0] op,
   output ex_ctrl_t   bundle,
   output logic       illegal
);

   always_comb begin
      bundle  = '0;
      illegal = 1'b0;
      case (op)
         OP_NOP: ;
         OP_R: begin
            bundle.reg_write = 1'b1;
            bundle.alu_op    = ALU_RTYPE;
         end
         OP_I: begin
            bundle.alu_src   = 1'b1;
            bundle.reg_write = 1'b1;
            bundle.alu_op    = ALU_ITYPE;
         end
         OP_LW: begin
            bundle.alu_src    = 1'b1;
            bundle.mem_read   = 1'b1;
            bundle.mem_to_reg = 1'b1;
            bundle.reg_write  = 1'b1;
            bundle.alu_op     = ALU_ADD;
         end
         OP_SW: begin
            bundle.alu_src   = 1'b1;
            bundle.mem_write = 1'b1;
            bundle.alu_op    = ALU_ADD;
         end
         OP_BEQ: begin
            bundle.branch = 1'b1;
            bundle.alu_op = ALU_SUB;
         end
         // Without JAL support the opcode falls through to the illegal path.
         OP_JAL: begin
            if (SUPPORT_JAL) begin
               bundle.jump      = 1'b1;
               bundle.reg_write = 1'b1;
               bundle.alu_op    = ALU_ADD;
            end else begin
               illegal = 1'b1;
            end
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ctrl_pipe.sv
// Main control for the 5-stage RV32 core: decodes the ID opcode and carries the
// control bundle through the EX, MEM and WB control registers.
module ctrl_pipe
   import ctrl_pipe_pkg::*;
#(
   parameter bit SUPPORT_JAL = 1'b1,
   parameter int ALUOP_W     = 2,
   parameter int CNT_W       = 8
) (
   input logic        clk_i,
   input logic        rst_i,
   ctrl_pipe_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   ex_ctrl_t         dec_bundle;
   logic             dec_illegal;
   ex_ctrl_t         id_ex;
   mem_ctrl_t        ex_mem;
   wb_ctrl_t         mem_wb;
   logic [CNT_W-1:0] illegal_cnt;
   logic             bubble;
   logic             count_en;

   ctrl_pipe_decode #(.SUPPORT_JAL(SUPPORT_JAL)) u_decode (
      .op      (bus.op_i),
      .bundle  (dec_bundle),
      .illegal (dec_illegal)
   );

   assign bubble   = bus.noop_i | bus.flush_i;
   assign count_en = dec_illegal & ~bus.stall_i & ~bubble & (illegal_cnt != CNT_MAX);

   // Stall freezes every stage; a bubble only replaces what enters EX.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         id_ex       <= '0;
         ex_mem      <= '0;
         mem_wb      <= '0;
         illegal_cnt <= '0;
      end else begin
         if (!bus.stall_i) begin
            id_ex  <= bubble ? '0 : dec_bundle;
            ex_mem <= to_mem(id_ex);
            mem_wb <= to_wb(ex_mem);
         end
         if (bus.cnt_clr_i) begin
            illegal_cnt <= '0;
         end else if (count_en) begin
            illegal_cnt <= illegal_cnt + 1'b1;
         end
      end
   end

   assign bus.illegal_o       = dec_illegal;
   assign bus.ex_alu_op_o     = ALUOP_W'(id_ex.alu_op);
   assign bus.ex_alu_src_o    = id_ex.alu_src;
   assign bus.ex_branch_o     = id_ex.branch;
   assign bus.ex_jump_o       = id_ex.jump;
   assign bus.ex_mem_read_o   = id_ex.mem_read;
   assign bus.ex_reg_write_o  = id_ex.reg_write;
   assign bus.mem_mem_read_o  = ex_mem.mem_read;
   assign bus.mem_mem_write_o = ex_mem.mem_write;
   assign bus.mem_reg_write_o = ex_mem.reg_write;
   assign bus.wb_reg_write_o  = mem_wb.reg_write;
   assign bus.wb_mem_to_reg_o = mem_wb.mem_to_reg;
   assign bus.illegal_cnt_o   = illegal_cnt;

endmodule
